// File: rtl/adder_chk_pkg.sv
// Shared types and golden model for the full-adder response checker.
package adder_chk_pkg;

  localparam int unsigned MAX_LATENCY = 7;
  localparam int unsigned VEC_W       = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  // One in-flight applied vector: {valid, {cin,y,x}}
  typedef struct packed {
    logic             valid;
    logic [VEC_W-1:0] vec;
  } vec_entry_t;

  // Golden full adder; vec = {cin,y,x}, result = {cout,a}
  function automatic logic [1:0] fa_ref(input logic [VEC_W-1:0] vec);
    logic x;
    logic y;
    logic cin;
    x   = vec[0];
    y   = vec[1];
    cin = vec[2];
    return {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
  endfunction

endpackage

// File: rtl/adder_vec_delay.sv
// LATENCY-deep shift pipeline of applied vectors, aligning them with DUT outputs.
module adder_vec_delay
  import adder_chk_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [VEC_W-1:0] in_vec,
  output logic             tap_valid,
  output logic [VEC_W-1:0] tap_vec
);

  vec_entry_t stage_q [LATENCY];

  // Clear flushes every in-flight entry so restarts never see stale vectors
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= {in_valid, in_vec};
      for (int i = 1; i < int'(LATENCY); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tap_valid = stage_q[LATENCY-1].valid;
  assign tap_vec   = stage_q[LATENCY-1].vec;

endmodule

// File: rtl/adder_resp_checker.sv
// Compares full-adder DUT outputs against a latency-aligned golden model and
// produces run counts, first-failure capture and a pass/fail verdict.
module adder_resp_checker
  import adder_chk_pkg::*;
#(
  parameter int unsigned LATENCY = 0,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned NUM_VEC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [2:0]       vec,
  input  logic             dut_a,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [2:0]       first_err_vec,
  output logic             first_err_valid
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VEC - 1);

  chk_state_e       state_q;
  chk_state_e       state_d;
  logic             pipe_in_valid;
  logic             tap_valid;
  logic [2:0]       tap_vec;
  logic             cmp_fire;
  logic             mismatch;
  logic             busy_d;
  logic             done_d;
  logic             pass_d;
  logic [CNT_W-1:0] err_cnt_d;
  logic [CNT_W-1:0] vec_cnt_d;
  logic [2:0]       first_err_vec_d;
  logic             first_err_valid_d;

  // Only vectors applied during RUN (and not in a restart cycle) enter the pipe
  assign pipe_in_valid = (state_q == RUN) && vec_valid && !start;

  generate
    if (LATENCY == 0) begin : g_comb_dut
      assign tap_valid = pipe_in_valid;
      assign tap_vec   = vec;
    end else begin : g_seq_dut
      logic pipe_clear;
      // Anything outside RUN, or a restart, discards in-flight vectors
      assign pipe_clear = start || (state_q != RUN);

      adder_vec_delay #(
        .LATENCY (LATENCY)
      ) u_vec_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (pipe_clear),
        .in_valid  (pipe_in_valid),
        .in_vec    (vec),
        .tap_valid (tap_valid),
        .tap_vec   (tap_vec)
      );
    end
  endgenerate

  assign cmp_fire = (state_q == RUN) && tap_valid;
  assign mismatch = ({dut_cout, dut_a} != fa_ref(tap_vec));

  // Next-state, counter and verdict logic
  always_comb begin
    state_d           = state_q;
    vec_cnt_d         = vec_cnt;
    err_cnt_d         = err_cnt;
    first_err_vec_d   = first_err_vec;
    first_err_valid_d = first_err_valid;

    if (start) begin
      state_d           = RUN;
      vec_cnt_d         = '0;
      err_cnt_d         = '0;
      first_err_vec_d   = '0;
      first_err_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
          if (cmp_fire) begin
            vec_cnt_d = vec_cnt + CNT_W'(1);
            if (mismatch) begin
              if (err_cnt != '1) begin
                err_cnt_d = err_cnt + CNT_W'(1);
              end
              if (!first_err_valid) begin
                first_err_vec_d   = tap_vec;
                first_err_valid_d = 1'b1;
              end
            end
            if (vec_cnt == LAST_CNT) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          state_d = DONE;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_cnt_d == '0);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      vec_cnt         <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      state_q         <= state_d;
      busy            <= busy_d;
      done            <= done_d;
      pass            <= pass_d;
      err_cnt         <= err_cnt_d;
      vec_cnt         <= vec_cnt_d;
      first_err_vec   <= first_err_vec_d;
      first_err_valid <= first_err_valid_d;
    end
  end

endmodule

// File: tb/tb_adder_resp_checker.sv
// Directed bench: a combinational-DUT checker instance and a LATENCY=2 instance.
module tb_adder_resp_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // LATENCY=0 instance
  logic        start0, vv0, a0, c0, inj0;
  logic [2:0]  vec0;
  logic        busy0, done0, pass0, fv0;
  logic [15:0] err0, cnt0;
  logic [2:0]  fev0;

  // LATENCY=2 instance
  logic        start2, vv2, a2, c2, dly2;
  logic [2:0]  vec2;
  logic        busy2, done2, pass2, fv2;
  logic [15:0] err2, cnt2;
  logic [2:0]  fev2;
  logic [1:0]  p1, p2;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference adder written arithmetically: {cout,a} = x + y + cin
  function automatic logic [1:0] fa_model(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

  // Combinational DUT model with optional A-inversion on vector 101
  assign {c0, a0} = fa_model(vec0) ^ {1'b0, inj0 && (vec0 == 3'b101)};

  // Registered DUT model, output tapped after 1 or 2 cycles
  always @(posedge clk) begin
    p1 <= fa_model(vec2);
    p2 <= p1;
  end
  assign {c2, a2} = dly2 ? p2 : p1;

  adder_resp_checker #(.LATENCY(0), .CNT_W(16), .NUM_VEC(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .vec_valid(vv0), .vec(vec0),
    .dut_a(a0), .dut_cout(c0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .vec_cnt(cnt0), .first_err_vec(fev0), .first_err_valid(fv0)
  );

  adder_resp_checker #(.LATENCY(2), .CNT_W(16), .NUM_VEC(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .vec_valid(vv2), .vec(vec2),
    .dut_a(a2), .dut_cout(c2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .vec_cnt(cnt2), .first_err_vec(fev2), .first_err_valid(fv2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit sel, input string tag);
    int n = 0;
    while (((sel ? done2 : done0) !== 1'b1) && n < 40) begin
      tick();
      n++;
    end
    n_cmp++;
    assert ((sel ? done2 : done0) === 1'b1)
    else begin
      n_fail++;
      $error("FAIL %s: done observed 0 expected 1 (timeout)", tag);
    end
  endtask

  task automatic start_run0();
    vv0    = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic send0(input logic [2:0] v);
    vv0  = 1'b1;
    vec0 = v;
    tick();
  endtask

  // Gapped stream of vectors 0..7 into the LATENCY=2 instance
  task automatic run2_gapped();
    logic [4:0] pat;
    int k;
    int cyc;
    pat    = 5'b01101;
    k      = 0;
    cyc    = 0;
    vv2    = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    while (k < 8) begin
      vv2 = pat[cyc % 5];
      if (vv2) begin
        vec2 = 3'(k);
        k++;
      end
      tick();
      cyc++;
    end
    vv2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; vv0 = 1'b0; vec0 = 3'd0; inj0 = 1'b0;
    start2 = 1'b0; vv2 = 1'b0; vec2 = 3'd0; dly2 = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_busy",  32'(busy0), 32'd0);
    check("rst_done",  32'(done0), 32'd0);
    check("rst_pass",  32'(pass0), 32'd0);
    check("rst_err",   32'(err0),  32'd0);
    check("rst_cnt",   32'(cnt0),  32'd0);
    check("rst_fv",    32'(fv0),   32'd0);
    check("rst_fev",   32'(fev0),  32'd0);

    // Clean run, all eight vectors
    start_run0();
    check("clean_busy", 32'(busy0), 32'd1);
    for (int i = 0; i < 8; i++) send0(3'(i));
    vv0 = 1'b0;
    wait_done(1'b0, "clean_done");
    check("clean_cnt",  32'(cnt0),  32'd8);
    check("clean_err",  32'(err0),  32'd0);
    check("clean_pass", 32'(pass0), 32'd1);
    check("clean_fv",   32'(fv0),   32'd0);
    check("clean_busy0", 32'(busy0), 32'd0);

    // A inverted only on vector 101
    inj0 = 1'b1;
    start_run0();
    check("inj_restart_done", 32'(done0), 32'd0);
    for (int i = 0; i < 8; i++) send0(3'(i));
    vv0 = 1'b0;
    wait_done(1'b0, "inj_done");
    check("inj_err",  32'(err0),  32'd1);
    check("inj_fev",  32'(fev0),  32'd5);
    check("inj_fv",   32'(fv0),   32'd1);
    check("inj_pass", 32'(pass0), 32'd0);
    inj0 = 1'b0;

    // Ten vectors, only eight counted
    start_run0();
    for (int i = 0; i < 10; i++) send0(3'(i % 8));
    vv0 = 1'b0;
    wait_done(1'b0, "extra_done");
    tick();
    check("extra_cnt",  32'(cnt0),  32'd8);
    check("extra_pass", 32'(pass0), 32'd1);

    // Restart mid-run after a mismatch
    inj0 = 1'b1;
    start_run0();
    send0(3'd5); send0(3'd4); send0(3'd3); send0(3'd2);
    check("pre_restart_err", 32'(err0), 32'd1);
    check("pre_restart_cnt", 32'(cnt0), 32'd4);
    inj0 = 1'b0;
    start_run0();
    check("restart_cnt_clr", 32'(cnt0), 32'd0);
    check("restart_busy",    32'(busy0), 32'd1);
    for (int i = 0; i < 8; i++) send0(3'(i));
    vv0 = 1'b0;
    wait_done(1'b0, "restart_done");
    check("restart_cnt",  32'(cnt0),  32'd8);
    check("restart_err",  32'(err0),  32'd0);
    check("restart_fv",   32'(fv0),   32'd0);
    check("restart_pass", 32'(pass0), 32'd1);

    // Reset mid-run
    start_run0();
    send0(3'd1); send0(3'd2); send0(3'd3);
    rst_n = 1'b0;
    send0(3'd4);
    rst_n = 1'b1;
    check("mrst_busy", 32'(busy0), 32'd0);
    check("mrst_done", 32'(done0), 32'd0);
    check("mrst_cnt",  32'(cnt0),  32'd0);
    check("mrst_err",  32'(err0),  32'd0);
    check("mrst_fv",   32'(fv0),   32'd0);
    send0(3'd5); send0(3'd6); send0(3'd7);
    vv0 = 1'b0;
    check("idle_ignore_cnt",  32'(cnt0),  32'd0);
    check("idle_ignore_busy", 32'(busy0), 32'd0);
    check("idle_ignore_done", 32'(done0), 32'd0);

    // LATENCY=2, DUT delayed 2 cycles, gapped valids
    dly2 = 1'b1;
    run2_gapped();
    wait_done(1'b1, "lat2_done");
    check("lat2_cnt",  32'(cnt2),  32'd8);
    check("lat2_err",  32'(err2),  32'd0);
    check("lat2_pass", 32'(pass2), 32'd1);
    check("lat2_busy", 32'(busy2), 32'd0);

    // Same stream, DUT delayed only 1 cycle
    dly2 = 1'b0;
    run2_gapped();
    wait_done(1'b1, "lat2_dly1_done");
    check("lat2_dly1_cnt",     32'(cnt2),        32'd8);
    check("lat2_dly1_err_nz",  32'(err2 != '0),  32'd1);
    check("lat2_dly1_fv",      32'(fv2),         32'd1);
    check("lat2_dly1_fev",     32'(fev2),        32'd4);
    check("lat2_dly1_pass",    32'(pass2),       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_resp_checker.md
Name: adder_resp_checker

Overview:
- Response-side checker for the single-bit full-adder DUT exercised in the opt_demorgan_reduce flow.
- The stimulus side drives {cin,y,x} vectors into the DUT. This block samples the DUT's sum (A) and carry (cout).
- It compares them against a golden model computed from the applied vector, delayed by a configurable DUT latency.
- It counts vectors and mismatches, captures the first failure, and raises a pass/fail verdict once a programmed number of vectors has been checked.

Parameters:
- LATENCY, 0, DUT cycles from vector applied to valid A/cout (0..7); 0 = combinational DUT, compared the same cycle.
- CNT_W, 16, width of vector and error counters.
- NUM_VEC, 8, vectors to check before the verdict (1..2^CNT_W-1).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  pulse; arms a new check run.
- vec_valid  in  1  applied vector valid this cycle.
- vec  in  3  applied vector {cin,y,x}.
- dut_a  in  1  DUT sum output A.
- dut_cout  in  1  DUT carry output cout.
- busy  out  1  run in progress.
- done  out  1  verdict valid; held until next start or reset.
- pass  out  1  1 = zero mismatches; valid when done.
- err_cnt  out  CNT_W  mismatches counted; saturates at all-ones.
- vec_cnt  out  CNT_W  vectors compared this run.
- first_err_vec  out  3  vector of the first mismatch.
- first_err_valid  out  1  first_err_vec is meaningful.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Golden model: exp_a = x^y^cin; exp_cout = (x&y)|(cin&(x^y)).
- Reset (rst_n=0 at a clk edge): FSM=IDLE; busy=0, done=0, pass=0, err_cnt=0, vec_cnt=0, first_err_vec=0, first_err_valid=0; delay pipeline valids cleared.
- Pipeline: LATENCY-deep shift register of {valid,vec}. Compare when the tap output is valid. LATENCY=0 compares vec directly in the vec_valid cycle.
- FSM IDLE: vec_valid ignored. start -> RUN next cycle; counters and first_err fields cleared, done=0.
- FSM RUN: busy=1.
  - On each valid compare: vec_cnt++.
  - On mismatch (dut_a!=exp_a or dut_cout!=exp_cout): err_cnt++ (saturating).
  - On the first mismatch of the run: latch first_err_vec and set first_err_valid.
  - The compare making vec_cnt reach NUM_VEC -> DRAIN.
- FSM DRAIN: discard remaining in-flight pipeline entries, then DONE. Vectors presented after NUM_VEC are never counted.
- FSM DONE: busy=0, done=1, pass=(err_cnt==0). start -> RUN with counters cleared; start and a compare in the same cycle: the compare is dropped.
- start while RUN or DRAIN: restart. Counters clear, the pipeline flushes, and the FSM stays RUN; the in-flight vectors are discarded.
- Reset mid-run: returns to IDLE immediately; no partial verdict is ever flagged done.
- Outputs are registered; counts update one cycle after the compare.

Decomposition:
- Package adder_chk_pkg: FSM state enum (IDLE, RUN, DRAIN, DONE), golden-model function fa_ref(vec) returning {cout,a}, MAX_LATENCY=7.
- Sub-module adder_vec_delay: the LATENCY-deep valid/vec shift pipeline with sync clear.
- Counters, FSM and compare stay in the top.

Test Plan:
- Correct DUT, LATENCY=0, vec 0..7 once after start -> vec_cnt=8, err_cnt=0, done=1, pass=1, first_err_valid=0.
- DUT model with A inverted only for vec=3'b101 -> err_cnt=1, first_err_vec=3'b101, pass=0 at done.
- LATENCY=2 with DUT outputs delayed 2 cycles, vec_valid gapped (1,0,1,1,0...) -> all 8 compared, pass=1. The same outputs delayed 1 cycle -> err_cnt>0.
- 10 vectors driven with NUM_VEC=8 -> vec_cnt stops at 8; the extra 2 are ignored.
- start pulsed after 4 vectors, then 8 clean vectors -> vec_cnt=8, err_cnt=0. A pre-restart mismatch must not persist.
- rst_n low one cycle mid-run -> all outputs 0 next cycle, FSM IDLE; vec_valid ignored until start.
